// File: rtl/adc_result_capture.sv
// Captures encoder words after a pipeline-fill delay and sums groups of 2^AVG_LOG2 samples.
// Each sum goes into a first-word-fall-through FIFO with a sticky overflow flag.
module adc_result_capture #(
  parameter int NUM_BITS    = 3,
  parameter int AVG_LOG2    = 2,
  parameter int FILL_CYCLES = 3,
  parameter int FIFO_DEPTH  = 4,
  localparam int SUM_W      = NUM_BITS + AVG_LOG2,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = ADDR_W + 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [NUM_BITS-1:0] d_i,
  input  logic                clear_i,
  input  logic                ready_i,
  output logic [SUM_W-1:0]    data_o,
  output logic                valid_o,
  output logic                overflow_o,
  output logic [LVL_W-1:0]    level_o
);

  typedef enum logic [1:0] {IDLE, FILL, ACCUM} state_e;

  localparam logic [3:0]       FILL_LAST = 4'(FILL_CYCLES - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  state_e                state_q;
  logic [3:0]            fill_cnt_q;
  logic [AVG_LOG2-1:0]   samp_cnt_q;
  logic [SUM_W-1:0]      acc_q;
  logic [SUM_W-1:0]      sum_d;
  logic                  push_q;
  logic [SUM_W-1:0]      push_data_q;

  logic [SUM_W-1:0]      mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      count_q, count_d;
  logic                  full, do_push, do_pop, drop;

  assign sum_d = acc_q + {{AVG_LOG2{1'b0}}, d_i};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      acc_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (!enable_i) begin
        state_q    <= IDLE;
        fill_cnt_q <= '0;
        samp_cnt_q <= '0;
        acc_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
          end
          FILL: begin
            if (fill_cnt_q == FILL_LAST) begin
              state_q    <= ACCUM;
              samp_cnt_q <= '0;
              acc_q      <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + 4'd1;
            end
          end
          ACCUM: begin
            // Last sample of the group: hand the full sum to the FIFO stage, restart at once.
            if (samp_cnt_q == '1) begin
              push_q      <= 1'b1;
              push_data_q <= sum_d;
              acc_q       <= '0;
              samp_cnt_q  <= '0;
            end else begin
              acc_q      <= sum_d;
              samp_cnt_q <= samp_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign full    = (count_q == FULL_LVL);
  assign valid_o = (count_q != '0);
  assign do_pop  = valid_o && ready_i;
  assign do_push = push_q && (!full || do_pop);
  assign drop    = push_q && full && !do_pop;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; emptiness is tracked by count_q and data_o is gated by valid_o.
  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop)         overflow_o <= 1'b1;
      else if (clear_i) overflow_o <= 1'b0;
    end
  end

  assign data_o  = valid_o ? mem[rd_ptr_q] : '0;
  assign level_o = count_q;

endmodule

// File: tb/tb_adc_result_capture.sv
// Directed bench for adc_result_capture at default parameters; outputs sampled 1 ns after each rising edge.
module tb_adc_result_capture;

  logic       clock_i = 1'b0;
  logic       reset_i, enable_i, clear_i, ready_i;
  logic [2:0] d_i;
  logic [4:0] data_o;
  logic       valid_o, overflow_o;
  logic [2:0] level_o;

  int passed = 0;
  int total  = 0;

  adc_result_capture dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .d_i        (d_i),
    .clear_i    (clear_i),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0; d_i = '0;
    tick(2);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; enable_i = 1'b1; clear_i = 1'b1; ready_i = 1'b1; d_i = 3'd7;
    tick(2);
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
    total++; if (level_o !== 3'd0) $display("FAIL reset_level: got %0d want 0", level_o); else passed++;
    total++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_o); else passed++;
    total++; if (data_o !== 5'd0) $display("FAIL reset_data: got %0d want 0", data_o); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    enable_i = 1'b1; d_i = 3'd5; ready_i = 1'b1;
    tick(8);  // edges 0..7: fill, then four samples
    total++; if (valid_o !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", valid_o); else passed++;
    tick(1);  // edge 8
    total++; if (valid_o !== 1'b1) $display("FAIL basic_valid: got %b want 1", valid_o); else passed++;
    total++; if (data_o !== 5'd20) $display("FAIL basic_data: got %0d want 20", data_o); else passed++;
    total++; if (level_o !== 3'd1) $display("FAIL basic_level: got %0d want 1", level_o); else passed++;
    tick(1);  // edge 9: popped
    total++; if (valid_o !== 1'b0) $display("FAIL basic_popped: got %b want 0", valid_o); else passed++;
    tick(3);  // edge 12: next result
    total++; if (valid_o !== 1'b1 || data_o !== 5'd20)
      $display("FAIL basic_second: got v=%b d=%0d want v=1 d=20", valid_o, data_o); else passed++;
  endtask

  task automatic test_patterns();
    logic [2:0] seq [4] = '{3'd7, 3'd0, 3'd3, 3'd1};
    do_reset();
    enable_i = 1'b1; ready_i = 1'b1; d_i = 3'd6;
    tick(4);  // fill; d_i ignored
    for (int i = 0; i < 4; i++) begin
      d_i = seq[i];
      tick(1);
    end
    d_i = 3'd7;
    tick(1);  // edge 8
    total++; if (data_o !== 5'd11 || valid_o !== 1'b1)
      $display("FAIL pattern_sum: got v=%b d=%0d want v=1 d=11", valid_o, data_o); else passed++;
    tick(4);  // edge 12
    total++; if (data_o !== 5'd28 || valid_o !== 1'b1)
      $display("FAIL pattern_max: got v=%b d=%0d want v=1 d=28", valid_o, data_o); else passed++;
  endtask

  task automatic test_overflow();
    logic [4:0] want [4] = '{5'd4, 5'd8, 5'd12, 5'd16};
    do_reset();
    enable_i = 1'b1; ready_i = 1'b0;
    tick(4);
    for (int r = 0; r < 5; r++) begin
      d_i = 3'(r + 1);
      tick(4);
    end
    // edge 23: four stored, fifth result waiting to be written
    total++; if (level_o !== 3'd4) $display("FAIL ovf_level: got %0d want 4", level_o); else passed++;
    total++; if (overflow_o !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow_o); else passed++;
    enable_i = 1'b0;
    tick(1);
    total++; if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow_o); else passed++;
    total++; if (level_o !== 3'd4) $display("FAIL ovf_level_kept: got %0d want 4", level_o); else passed++;
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    total++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow_o); else passed++;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (valid_o !== 1'b1 || data_o !== want[i])
        $display("FAIL ovf_order%0d: got v=%b d=%0d want v=1 d=%0d", i, valid_o, data_o, want[i]); else passed++;
      tick(1);
    end
    total++; if (valid_o !== 1'b0 || level_o !== 3'd0)
      $display("FAIL ovf_drained: got v=%b lvl=%0d want v=0 lvl=0", valid_o, level_o); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [4:0] want [4] = '{5'd8, 5'd12, 5'd16, 5'd20};
    do_reset();
    enable_i = 1'b1; ready_i = 1'b0;
    tick(4);
    for (int r = 0; r < 4; r++) begin
      d_i = 3'(r + 1);
      tick(4);
    end
    d_i = 3'd5;
    tick(4);  // edge 23
    total++; if (level_o !== 3'd4) $display("FAIL full_level: got %0d want 4", level_o); else passed++;
    ready_i = 1'b1; d_i = 3'd6;
    tick(1);  // edge 24: push and pop together while full
    ready_i = 1'b0;
    total++; if (level_o !== 3'd4) $display("FAIL full_pp_level: got %0d want 4", level_o); else passed++;
    total++; if (overflow_o !== 1'b0) $display("FAIL full_pp_ovf: got %b want 0", overflow_o); else passed++;
    total++; if (data_o !== 5'd8) $display("FAIL full_pp_head: got %0d want 8", data_o); else passed++;
    tick(3);  // edge 27: sum of 6s pending, FIFO full
    enable_i = 1'b0; clear_i = 1'b1;
    tick(1);  // edge 28: drop and clear together
    clear_i = 1'b0;
    total++; if (overflow_o !== 1'b1) $display("FAIL full_set_wins: got %b want 1", overflow_o); else passed++;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (valid_o !== 1'b1 || data_o !== want[i])
        $display("FAIL full_order%0d: got v=%b d=%0d want v=1 d=%0d", i, valid_o, data_o, want[i]); else passed++;
      tick(1);
    end
  endtask

  task automatic test_reenable();
    do_reset();
    enable_i = 1'b1; ready_i = 1'b1; d_i = 3'd7;
    tick(6);  // fill + two samples
    enable_i = 1'b0;
    tick(1);
    enable_i = 1'b1; d_i = 3'd7;
    tick(4);  // idle->fill plus three fill cycles, d_i ignored
    d_i = 3'd1;
    tick(4);
    total++; if (valid_o !== 1'b0) $display("FAIL reen_early: got %b want 0", valid_o); else passed++;
    tick(1);
    total++; if (valid_o !== 1'b1 || data_o !== 5'd4)
      $display("FAIL reen_sum: got v=%b d=%0d want v=1 d=4", valid_o, data_o); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable_i = 1'b1; ready_i = 1'b0; d_i = 3'd2;
    tick(14);  // two results queued, two samples into the third
    total++; if (level_o !== 3'd2) $display("FAIL rmid_level_pre: got %0d want 2", level_o); else passed++;
    reset_i = 1'b1; ready_i = 1'b1; clear_i = 1'b1;
    tick(1);
    total++; if (valid_o !== 1'b0 || level_o !== 3'd0 || overflow_o !== 1'b0)
      $display("FAIL rmid_cleared: got v=%b lvl=%0d ovf=%b want 0/0/0", valid_o, level_o, overflow_o); else passed++;
    reset_i = 1'b0; clear_i = 1'b0; d_i = 3'd3;
    tick(8);
    total++; if (valid_o !== 1'b0) $display("FAIL rmid_early: got %b want 0", valid_o); else passed++;
    tick(1);
    total++; if (valid_o !== 1'b1 || data_o !== 5'd12)
      $display("FAIL rmid_restart: got v=%b d=%0d want v=1 d=12", valid_o, data_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_overflow();
    test_full_push_pop();
    test_reenable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
